// File: rtl/mux_nway_reg_if.sv
// mux_nway_reg_if: handshake bundle between N producers, the registered selector and one consumer
interface mux_nway_reg_if #(parameter int WIDTH = 16, parameter int N = 4);
   localparam int SELW = $clog2(N);
   logic              mode;
   logic [SELW-1:0]   sel;
   logic [N-1:0]      in_valid;
   logic [N*WIDTH-1:0] in_data;
   logic [N-1:0]      in_ready;
   logic              out_valid;
   logic [WIDTH-1:0]  out_data;
   logic [SELW-1:0]   out_sel;
   logic              out_ready;
   modport master (output mode, sel, in_valid, in_data, out_ready,
                   input in_ready, out_valid, out_data, out_sel);
   modport slave (input mode, sel, in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data, out_sel);
endinterface

// File: rtl/mux_nway_reg.sv
// mux_nway_reg: registered N-way selector with fixed or round-robin choice and a one-entry output register
module mux_nway_reg #(
   parameter int WIDTH = 16,
   parameter int N = 4
) (
   input logic clk,
   input logic reset_n,
   mux_nway_reg_if.slave bus
);
   localparam int SELW = $clog2(N);
   logic [SELW-1:0] ptr, cand, lo_idx, hi_idx;
   logic has, lo_has, hi_has, load;
   logic [WIDTH-1:0] cand_data;
   assign load = !bus.out_valid || bus.out_ready;
   // descending scan leaves the lowest index at or above ptr in hi_*, wrap-around winner in lo_*
   always_comb begin
      lo_has = 1'b0;
      hi_has = 1'b0;
      lo_idx = '0;
      hi_idx = '0;
      has = 1'b0;
      cand = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (bus.in_valid[i] && SELW'(i) >= ptr) begin
            hi_has = 1'b1;
            hi_idx = SELW'(i);
         end
         if (bus.in_valid[i] && SELW'(i) < ptr) begin
            lo_has = 1'b1;
            lo_idx = SELW'(i);
         end
         if (!bus.mode && bus.sel == SELW'(i) && bus.in_valid[i]) begin
            has = 1'b1;
            cand = SELW'(i);
         end
      end
      if (bus.mode) begin
         has = hi_has || lo_has;
         cand = hi_has ? hi_idx : lo_idx;
      end
   end
   always_comb begin
      cand_data = '0;
      for (int i = 0; i < N; i++)
         if (cand == SELW'(i)) cand_data = bus.in_data[i*WIDTH +: WIDTH];
   end
   always_comb begin
      bus.in_ready = '0;
      for (int i = 0; i < N; i++)
         bus.in_ready[i] = reset_n && load && has && cand == SELW'(i);
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.out_valid <= 1'b0;
         bus.out_data <= '0;
         bus.out_sel <= '0;
         ptr <= '0;
      end else if (load) begin
         bus.out_valid <= has;
         if (has) begin
            bus.out_data <= cand_data;
            bus.out_sel <= cand;
            ptr <= (cand == SELW'(N - 1)) ? '0 : cand + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_mux_nway_reg.sv
// tb_mux_nway_reg: directed and random checks of mux_nway_reg against a queue-free behavioural model
module tb_mux_nway_reg;
   localparam int W = 16;
   localparam int N = 4;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;
   mux_nway_reg_if #(.WIDTH(W), .N(N)) bus ();
   mux_nway_reg #(.WIDTH(W), .N(N)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
   mux_nway_reg_if #(.WIDTH(W), .N(3)) bus3 ();
   mux_nway_reg #(.WIDTH(W), .N(3)) dut3 (.clk(clk), .reset_n(reset_n), .bus(bus3));
   int checks = 0;
   int fails = 0;
   bit m_valid;
   logic [W-1:0] m_data;
   int m_sel, m_ptr;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask
   // channel that wins this cycle, or -1 when nobody is eligible
   function automatic int pick(input bit md, input int s, input logic [N-1:0] v, input int p);
      if (!md) return (s < N && v[s]) ? s : -1;
      for (int k = 0; k < N; k++)
         if (v[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction
   task automatic model_reset();
      m_valid = 0;
      m_data = '0;
      m_sel = 0;
      m_ptr = 0;
   endtask
   task automatic step();
      int idx;
      bit load;
      #1;
      load = !m_valid || bus.out_ready;
      idx = pick(bus.mode, int'(bus.sel), bus.in_valid, m_ptr);
      chk("in_ready", 32'(bus.in_ready), (load && idx >= 0) ? 32'(1 << idx) : 32'd0);
      @(posedge clk);
      if (load) begin
         if (idx >= 0) begin
            m_valid = 1;
            m_data = bus.in_data[idx*W +: W];
            m_sel = idx;
            m_ptr = (idx + 1) % N;
         end else m_valid = 0;
      end
      #1;
      chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
      chk("out_data", 32'(bus.out_data), 32'(m_data));
      chk("out_sel", 32'(bus.out_sel), 32'(m_sel));
   endtask
   task automatic drive(input bit md, input int s, input logic [N-1:0] v, input bit rdy);
      bus.mode = md;
      bus.sel = 2'(s);
      bus.in_valid = v;
      bus.out_ready = rdy;
   endtask
   initial begin
      drive(0, 0, '0, 0);
      bus.in_data = '0;
      bus3.mode = 0;
      bus3.sel = '0;
      bus3.in_valid = '0;
      bus3.in_data = '0;
      bus3.out_ready = 1'b0;
      model_reset();
      #12;
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_out_data", 32'(bus.out_data), 0);
      chk("rst_in_ready", 32'(bus.in_ready), 0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      bus.in_data = {16'h00DD, 16'h00CC, 16'h00BB, 16'h00AA};
      drive(1, 0, 4'b1111, 1);
      for (int i = 0; i < 6; i++) begin
         step();
         chk("rr_fair_sel", 32'(bus.out_sel), 32'(i % 4));
      end
      drive(1, 0, 4'b1010, 1);
      step();
      chk("rr_wrap_a", 32'(bus.out_sel), 3);
      step();
      chk("rr_wrap_b", 32'(bus.out_sel), 1);
      step();
      chk("rr_wrap_c", 32'(bus.out_sel), 3);
      drive(0, 2, 4'b1111, 1);
      #1;
      chk("fixed_in_ready", 32'(bus.in_ready), 32'b0100);
      step();
      chk("fixed_data", 32'(bus.out_data), 32'h00CC);
      bus.in_data[15:0] = 16'h1234;
      drive(0, 0, 4'b1111, 1);
      step();
      bus.in_data[15:0] = 16'h5678;
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("bp_hold", 32'(bus.out_data), 32'h1234);
      end
      bus.out_ready = 1'b1;
      step();
      chk("bp_resume", 32'(bus.out_data), 32'h5678);
      bus.out_ready = 1'b0;
      step();
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      chk("arst_out_valid", 32'(bus.out_valid), 0);
      chk("arst_out_data", 32'(bus.out_data), 0);
      chk("arst_out_sel", 32'(bus.out_sel), 0);
      chk("arst_in_ready", 32'(bus.in_ready), 0);
      #1;
      reset_n = 1'b1;
      drive(1, 3, 4'b1111, 1);
      step();
      chk("arst_first_grant", 32'(bus.out_sel), 0);
      for (int i = 0; i < 400; i++) begin
         drive($urandom % 2, $urandom % 4, 4'($urandom), ($urandom % 4) != 0);
         bus.in_data = {$urandom, $urandom};
         step();
      end
      bus3.mode = 0;
      bus3.sel = 2'd1;
      bus3.in_valid = 3'b111;
      bus3.in_data = {16'h0333, 16'h0777, 16'h0111};
      bus3.out_ready = 1'b1;
      #1;
      chk("n3_in_ready", 32'(bus3.in_ready), 32'b010);
      @(posedge clk);
      #1;
      chk("n3_data", 32'(bus3.out_data), 32'h0777);
      bus3.sel = 2'd3;
      #1;
      chk("n3_oor_ready", 32'(bus3.in_ready), 0);
      @(posedge clk);
      #1;
      chk("n3_oor_valid", 32'(bus3.out_valid), 0);
      chk("n3_oor_data", 32'(bus3.out_data), 32'h0777);
      chk("n3_oor_sel", 32'(bus3.out_sel), 1);
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end
endmodule

// File: doc/mux_nway_reg.md
# mux_nway_reg

Parametrised, registered N-way selector for WIDTH-bit data with valid/ready handshaking on every channel. It generalises the combinational 16-bit 4-way mux from the gates library. It adds a run-time choice between fixed selection (sel-driven) and round-robin arbitration, and a one-entry output register with backpressure. It sits between multiple producer blocks (register-file read ports, memory-mapped sources) and a single consumer on the datapath.

## Interface

Parameters:
- WIDTH, 16, data width of each channel and of the output.
- N, 4, number of input channels, N >= 2; need not be a power of two.
- SELW (localparam), $clog2(N), width of sel and out_sel.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset_n  input  1  reset, asynchronous and active-low.
- mode  input  1  0 = fixed select by sel; 1 = round-robin.
- sel  input  SELW  channel index used when mode = 0.
- in_valid  input  N  per-channel valid; bit i belongs to channel i.
- in_data  input  N*WIDTH  flattened channel data; channel i at [i*WIDTH +: WIDTH].
- in_ready  output  N  per-channel ready; at most one bit high per cycle.
- out_valid  output  1  output register holds a beat.
- out_data  output  WIDTH  registered data of the held beat.
- out_sel  output  SELW  index of the channel that supplied the held beat.
- out_ready  input  1  consumer accepts the beat this cycle.

## Operation

- State: output register (out_valid, out_data, out_sel) and round-robin pointer ptr (SELW bits). EMPTY/FULL is encoded directly by out_valid.
- Load enable: load = !out_valid || out_ready. This gives full throughput of one beat per cycle while the consumer is ready.
- Candidate selection (combinational, from this cycle's inputs):
  - mode 0: channel sel, only if sel < N and in_valid[sel] = 1; otherwise no candidate.
  - mode 1: the first channel with in_valid set, searching ptr, ptr+1, … N-1, 0, … ptr-1 (modulo N).
- Grant: in_ready[i] = load && (i == candidate). With no candidate, in_ready is all zero.
- Transfer on channel i (in_valid[i] && in_ready[i]):
  - out_data <= channel i data; out_sel <= i; out_valid <= 1.
  - ptr <= (i == N-1) ? 0 : i+1. The pointer updates on grants in either mode.
- Load with no candidate: out_valid <= 0; out_data and out_sel hold their last values.
- Stall (out_valid && !out_ready): all registers hold; in_ready = 0.
- Mode or sel changes act on the next grant decision only. The beat already in the register is never altered.
- in_data of non-granted channels is ignored. A deasserted in_valid never produces a grant.
- Reset (reset_n low, asynchronous, at any time, including mid-stall): out_valid = 0, out_data = 0, out_sel = 0, ptr = 0. in_ready = 0 while reset_n is low. First grant is possible on the first rising edge after deassertion.

## Timing

- Latency: one cycle from an accepted input to out_valid/out_data.
- Throughput: one beat per cycle with out_ready held high.
- in_ready depends combinationally on mode, sel, in_valid, out_valid, out_ready and ptr. It has no combinational path from in_data.
- Outputs out_valid, out_data and out_sel are driven directly from flops.
- Simultaneous out_ready and new grant in the same cycle: the old beat is consumed and the new beat is loaded at the same edge, with no bubble.

## Test plan

- Reset: drive reset_n low asynchronously between edges while out_valid = 1 and out_ready = 0 → out_valid = 0, out_data = 0x0000, out_sel = 0 immediately. After release, the first grant comes from channel 0 in mode 1.
- Fixed select (N=4, WIDTH=16): mode=0, sel=2, all valid, channel data 0x00AA/0x00BB/0x00CC/0x00DD → in_ready = 4'b0100. Next cycle out_valid = 1, out_data = 0x00CC, out_sel = 2.
- Round-robin fairness: mode=1, all four valid continuously, out_ready=1 → out_sel = 0,1,2,3,0,1 on consecutive cycles, out_valid constantly 1.
- Backpressure: FULL with out_data = 0x1234, out_ready=0 for 3 cycles → out_data stays 0x1234 and in_ready = 0 each cycle. On the cycle out_ready returns to 1, a new grant occurs and the next beat appears on the following edge.
- Round-robin skip and wrap: ptr=2, only in_valid[1] and in_valid[3] set → grant 3 first, then 1, then 3 again. ptr values after each grant: 0, 2, 0.
- Out-of-range select (N=3, SELW=2): mode=0, sel=3, all valid, out_ready=1 → in_ready = 3'b000. out_valid falls to 0 after the pending beat is consumed. out_data still holds the last value.
